// File: rtl/vga_scanner_if.sv
// Bus between the raster scanner and the renderer/VGA connector.
// master = vga_scanner (drives coordinates, sync and colour, samples pixel);
// slave  = renderer / display side.
interface vga_scanner_if;
  logic        pixel;
  logic [11:0] vga_x;
  logic [11:0] vga_y;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic [11:0] rgb;
  logic        frame_tick;

  modport master (
    input  pixel,
    output vga_x, vga_y, hsync, vsync, video_on, rgb, frame_tick
  );

  modport slave (
    output pixel,
    input  vga_x, vga_y, hsync, vsync, video_on, rgb, frame_tick
  );
endinterface

// File: rtl/vga_scanner.sv
// VGA raster timing generator and video output stage.
// Free-running h/v counters publish the current coordinate to the renderer.
// Blanking and sync are delayed by PIXEL_LATENCY clocks so they line up with
// the renderer's pixel reply, then registered once more together with rgb.
// Optional feature: define VGA_BORDER_EN to force a 1-pixel white frame
// around the visible area (monitor alignment aid).
module vga_scanner #(
  parameter int H_VISIBLE     = 640,
  parameter int H_FRONT       = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BACK        = 48,
  parameter int V_VISIBLE     = 480,
  parameter int V_FRONT       = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BACK        = 33,
  parameter bit SYNC_ACTIVE   = 1'b0,
  parameter int PIXEL_LATENCY = 1
) (
  input  logic          pixel_clk,
  input  logic          rst_n,
  vga_scanner_if.master bus
);

  localparam logic [11:0] H_VIS      = 12'(H_VISIBLE);
  localparam logic [11:0] H_SYNC_BEG = 12'(H_VISIBLE + H_FRONT);
  localparam logic [11:0] H_SYNC_END = 12'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [11:0] H_LAST     = 12'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [11:0] V_VIS      = 12'(V_VISIBLE);
  localparam logic [11:0] V_SYNC_BEG = 12'(V_VISIBLE + V_FRONT);
  localparam logic [11:0] V_SYNC_END = 12'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [11:0] V_LAST     = 12'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

  logic [11:0] r_h;
  logic [11:0] r_v;
  logic        w_h_wrap;
  logic        w_raw_active;
  logic        w_raw_hs;
  logic        w_raw_vs;

  logic [PIXEL_LATENCY-1:0] r_active_pipe;
  logic [PIXEL_LATENCY-1:0] r_hs_pipe;
  logic [PIXEL_LATENCY-1:0] r_vs_pipe;
  logic                     w_active_d;
  logic                     w_lit;

  logic        r_hsync;
  logic        r_vsync;
  logic        r_video_on;
  logic [11:0] r_rgb;
  logic        r_frame_tick;

  assign w_h_wrap = (r_h == H_LAST);

  // Raster counters: h every clock, v on each h wrap.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would chain r_h into r_v in one clock.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_h_wrap) begin
      r_h <= '0;
      r_v <= (r_v == V_LAST) ? 12'd0 : r_v + 12'd1;
    end else begin
      r_h <= r_h + 12'd1;
    end
  end

  // Undelayed phase decode of the current coordinate.
  always_comb begin
    w_raw_active = (r_h < H_VIS) && (r_v < V_VIS);
    w_raw_hs     = (r_h >= H_SYNC_BEG) && (r_h < H_SYNC_END);
    w_raw_vs     = (r_v >= V_SYNC_BEG) && (r_v < V_SYNC_END);
  end

  // Alignment pipeline: stage PIXEL_LATENCY-1 coincides with the pixel reply.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active_pipe <= '0;
      r_hs_pipe     <= '0;
      r_vs_pipe     <= '0;
    end else begin
      r_active_pipe[0] <= w_raw_active;
      r_hs_pipe[0]     <= w_raw_hs;
      r_vs_pipe[0]     <= w_raw_vs;
      for (int i = 1; i < PIXEL_LATENCY; i++) begin
        r_active_pipe[i] <= r_active_pipe[i-1];
        r_hs_pipe[i]     <= r_hs_pipe[i-1];
        r_vs_pipe[i]     <= r_vs_pipe[i-1];
      end
    end
  end

  assign w_active_d = r_active_pipe[PIXEL_LATENCY-1];

`ifdef VGA_BORDER_EN
  logic [11:0] r_x_pipe [PIXEL_LATENCY];
  logic [11:0] r_y_pipe [PIXEL_LATENCY];
  logic [11:0] w_x_d;
  logic [11:0] w_y_d;

  // Coordinate delayed alongside active so the border lines up with pixel.
  // NOTE: this small array is reset on purpose so no stale coordinate can
  // paint a border right after reset; large memories would not be reset.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIXEL_LATENCY; i++) begin
        r_x_pipe[i] <= '0;
        r_y_pipe[i] <= '0;
      end
    end else begin
      r_x_pipe[0] <= r_h;
      r_y_pipe[0] <= r_v;
      for (int i = 1; i < PIXEL_LATENCY; i++) begin
        r_x_pipe[i] <= r_x_pipe[i-1];
        r_y_pipe[i] <= r_y_pipe[i-1];
      end
    end
  end

  assign w_x_d = r_x_pipe[PIXEL_LATENCY-1];
  assign w_y_d = r_y_pipe[PIXEL_LATENCY-1];

  // Pixel is lit by the renderer or by the alignment border.
  always_comb begin
    w_lit = bus.pixel ||
            (w_x_d == 12'd0) || (w_x_d == H_VIS - 12'd1) ||
            (w_y_d == 12'd0) || (w_y_d == V_VIS - 12'd1);
  end
`else
  // Pixel is lit only by the renderer.
  always_comb begin
    w_lit = bus.pixel;
  end
`endif

  // Output register stage: sync levels, blanking-masked colour, frame tick.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync      <= ~SYNC_ACTIVE;
      r_vsync      <= ~SYNC_ACTIVE;
      r_video_on   <= 1'b0;
      r_rgb        <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_hsync      <= r_hs_pipe[PIXEL_LATENCY-1] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      r_vsync      <= r_vs_pipe[PIXEL_LATENCY-1] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      r_video_on   <= w_active_d;
      r_rgb        <= (w_active_d && w_lit) ? 12'hFFF : 12'h000;
      r_frame_tick <= w_h_wrap && (r_v == V_VIS - 12'd1);
    end
  end

  assign bus.vga_x      = r_h;
  assign bus.vga_y      = r_v;
  assign bus.hsync      = r_hsync;
  assign bus.vsync      = r_vsync;
  assign bus.video_on   = r_video_on;
  assign bus.rgb        = r_rgb;
  assign bus.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_scanner.sv
// Self-checking bench for vga_scanner. Uses a reduced raster so several whole
// frames fit in a short run. The reference model derives every expected output
// from the number of clocks since reset release with plain div/mod arithmetic.
module tb_vga_scanner;

  localparam int HV = 20, HF = 4, HS = 6, HB = 5;
  localparam int VV = 12, VF = 2, VS = 2, VB = 3;
  localparam int LAT   = 2;
  localparam int HT    = HV + HF + HS + HB;
  localparam int VT    = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  localparam int MODE_RANDOM = 0;
  localparam int MODE_TARGET = 1;
  localparam int MODE_ONES   = 2;

  logic pixel_clk = 1'b0;
  logic rst_n     = 1'b0;

  vga_scanner_if bus ();

  vga_scanner #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE(1'b0), .PIXEL_LATENCY(LAT)
  ) dut (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .bus       (bus.master)
  );

  always #5 pixel_clk = ~pixel_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n        = 0;          // clocks since reset release
  bit pix_hist [int];        // pixel value driven during cycle n
  int ticks [$];             // cycle numbers at which frame_tick was seen
  int fff_count;

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  function automatic int cx(input int c); return c % HT; endfunction
  function automatic int cy(input int c); return (c / HT) % VT; endfunction

  function automatic bit model_border(input int x, input int y);
`ifdef VGA_BORDER_EN
    return (x == 0) || (x == HV-1) || (y == 0) || (y == VV-1);
`else
    return 1'b0;
`endif
  endfunction

  // Expected output at cycle c (outputs show the coordinate LAT+1 clocks old).
  task automatic model(input int c, output int ex, output int ey, output bit ehs,
                       output bit evs, output bit evon, output logic [11:0] ergb,
                       output bit etick);
    int px, py;
    ex    = cx(c);
    ey    = cy(c);
    etick = (ex == 0) && (ey == VV);
    ehs   = 1'b1;
    evs   = 1'b1;
    evon  = 1'b0;
    ergb  = 12'h000;
    if (c > LAT) begin
      px   = cx(c - LAT - 1);
      py   = cy(c - LAT - 1);
      ehs  = !(px >= HV + HF && px < HV + HF + HS);
      evs  = !(py >= VV + VF && py < VV + VF + VS);
      evon = (px < HV) && (py < VV);
      if (evon && (pix_hist[c-1] || model_border(px, py))) ergb = 12'hFFF;
    end
  endtask

  task automatic check_all();
    int ex, ey;
    bit ehs, evs, evon, etick;
    logic [11:0] ergb;
    model(n, ex, ey, ehs, evs, evon, ergb, etick);
    check("vga_x",      bus.vga_x,      12'(ex));
    check("vga_y",      bus.vga_y,      12'(ey));
    check("hsync",      12'(bus.hsync),      12'(ehs));
    check("vsync",      12'(bus.vsync),      12'(evs));
    check("video_on",   12'(bus.video_on),   12'(evon));
    check("rgb",        bus.rgb,        ergb);
    check("frame_tick", 12'(bus.frame_tick), 12'(etick));
    if (bus.frame_tick === 1'b1) ticks.push_back(n);
    if (bus.rgb === 12'hFFF) fff_count++;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_hsync"},    12'(bus.hsync),      12'd1);
    check({tag, "_vsync"},    12'(bus.vsync),      12'd1);
    check({tag, "_video_on"}, 12'(bus.video_on),   12'd0);
    check({tag, "_rgb"},      bus.rgb,             12'h000);
    check({tag, "_tick"},     12'(bus.frame_tick), 12'd0);
    check({tag, "_x"},        bus.vga_x,           12'd0);
    check({tag, "_y"},        bus.vga_y,           12'd0);
  endtask

  // Pixel for the current cycle; the target mode lights only (5,7) as the
  // renderer would, answering LAT clocks after that coordinate appears.
  task automatic drive_pixel(input int mode);
    bit p;
    case (mode)
      MODE_TARGET: p = (n >= LAT) && (cx(n - LAT) == 5) && (cy(n - LAT) == 7);
      MODE_ONES:   p = 1'b1;
      default:     p = 1'($urandom_range(0, 1));
    endcase
    pix_hist[n] = p;
    bus.pixel   = p;
  endtask

  task automatic run(input int cycles, input int mode);
    for (int k = 0; k < cycles; k++) begin
      @(posedge pixel_clk);
      n++;
      @(negedge pixel_clk);
      check_all();
      drive_pixel(mode);
    end
  endtask

  task automatic release_reset(input int mode);
    @(negedge pixel_clk);
    rst_n = 1'b1;
    n = 0;
    pix_hist.delete();
    ticks.delete();
    drive_pixel(mode);
  endtask

  initial begin
    int ex, ey;
    bit ehs, evs, evon, etick, found;
    logic [11:0] ergb;
    bus.pixel = 1'b0;

    // Reset held for 5 clocks: outputs idle, counters parked at (0,0).
    repeat (5) begin
      @(negedge pixel_clk);
      check_reset_state("in_reset");
    end

    // Two frames of random pixels; every output compared every clock.
    release_reset(MODE_RANDOM);
    run(2 * FRAME, MODE_RANDOM);
    check("tick_count", 12'(ticks.size()), 12'd2);
    if (ticks.size() >= 2)
      check("tick_period", 12'(ticks[1] - ticks[0]), 12'(FRAME));

    // Renderer lights only (5,7): one white pixel per frame (plus border).
    run(LAT + 3, MODE_TARGET);
    fff_count = 0;
    run(FRAME, MODE_TARGET);
`ifdef VGA_BORDER_EN
    check("target_fff_count", 12'(fff_count), 12'(2 * HV + 2 * VV - 4 + 1));
`else
    check("target_fff_count", 12'(fff_count), 12'd1);
`endif

    // Pixel stuck high: rgb must still be masked in blanking.
    run(FRAME, MODE_ONES);

    // Advance until both syncs are asserted on the outputs, then reset mid-pulse.
    found = 1'b0;
    for (int k = 0; k < 2 * FRAME && !found; k++) begin
      model(n, ex, ey, ehs, evs, evon, ergb, etick);
      if (!ehs && !evs) found = 1'b1;
      else run(1, MODE_RANDOM);
    end
    check("sync_wait_found", 12'(found), 12'd1);
    check("pre_reset_hsync", 12'(bus.hsync), 12'd0);
    check("pre_reset_vsync", 12'(bus.vsync), 12'd0);
    #2 rst_n = 1'b0;
    #1 check_reset_state("async_reset");
    repeat (3) begin
      @(negedge pixel_clk);
      check_reset_state("held_reset");
    end

    // Restart cleanly: no leftover sync pulse, frame starts at (0,0).
    release_reset(MODE_RANDOM);
    run(FRAME + 50, MODE_RANDOM);
    check("restart_tick_count", 12'(ticks.size()), 12'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
